updown_sweep_ctrl: RTL

Sequencer that drives the enable/up_down inputs of an updown_counter instance, making it sweep repeatedly between two programmable bounds with a programmable dwell at each end. Observes the counter's output, so the counter can land exactly on each bound. Sits beside the counter in the counter subsystem. Software/top level issues start/abort and reads status.

---
 rtl/updown_sweep_pkg.sv | 18 +
 rtl/updown_counter.sv | 20 ++
 rtl/updown_sweep_ctrl_dwell_timer.sv | 27 ++
 rtl/updown_sweep_ctrl.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/updown_sweep_pkg.sv
// Shared types for the up/down sweep sequencer: FSM state encoding and
// counter direction constants.
package updown_sweep_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SEEK     = 3'd1,
        UP       = 3'd2,
        DWELL_HI = 3'd3,
        DOWN     = 3'd4,
        DWELL_LO = 3'd5,
        DONE     = 3'd6
    } sweep_state_e;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/updown_counter.sv
// Plain up/down counter driven by the sweep sequencer; wraps naturally.
module updown_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_down,
    output logic [WIDTH-1:0] out
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out <= '0;
        end else if (enable) begin
            out <= up_down ? out + 1'b1 : out - 1'b1;
        end
    end

endmodule

// File: rtl/updown_sweep_ctrl_dwell_timer.sv
// Dwell timer shared by both bound-hold states. Reloaded every cycle outside
// a dwell, so a dwell of length len lasts len+1 cycles before expire.
module sweep_dwell_timer #(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [DWELL_W-1:0] len,
    output logic               expire
);

    logic [DWELL_W-1:0] count_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= len;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign expire = (count_reg == '0);

endmodule

// File: rtl/updown_sweep_ctrl.sv
// Sequencer that sweeps an updown_counter between two latched bounds with a
// programmable dwell at each end, watching the counter value to land exactly.
module updown_sweep_ctrl
    import updown_sweep_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int DWELL_W = 4,
    parameter int PASS_W  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [WIDTH-1:0]   lo_bound,
    input  logic [WIDTH-1:0]   hi_bound,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [PASS_W-1:0]  passes,
    input  logic [WIDTH-1:0]   cnt_in,
    output logic               cnt_enable,
    output logic               cnt_up_down,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [PASS_W-1:0]  pass_cnt
);

    sweep_state_e       state_reg, state_next;
    logic [WIDTH-1:0]   lo_reg, hi_reg;
    logic [DWELL_W-1:0] dwell_reg;
    logic [PASS_W-1:0]  passes_reg;
    logic [PASS_W-1:0]  pass_cnt_reg, pass_cnt_next;
    logic               err_reg, err_next;
    logic               dir_reg, dir_next;
    logic               enable_next;
    logic               latch;
    logic               dwell_expire;
    logic               in_dwell;

    // One extra bit keeps the +1 landing compares free of wrap artefacts.
    logic [WIDTH:0] cnt_ext, lo_ext, hi_ext;
    assign cnt_ext = {1'b0, cnt_in};
    assign lo_ext  = {1'b0, lo_reg};
    assign hi_ext  = {1'b0, hi_reg};

    assign in_dwell = (state_reg == DWELL_HI) || (state_reg == DWELL_LO);

    sweep_dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_dwell_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (!in_dwell),
        .len    (dwell_reg),
        .expire (dwell_expire)
    );

    always_comb begin
        state_next    = state_reg;
        enable_next   = 1'b0;
        dir_next      = dir_reg;
        pass_cnt_next = pass_cnt_reg;
        err_next      = err_reg;
        latch         = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (lo_bound < hi_bound) begin
                        latch         = 1'b1;
                        pass_cnt_next = '0;
                        err_next      = 1'b0;
                        state_next    = SEEK;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            SEEK: begin
                if (cnt_in == lo_reg) begin
                    state_next = UP;
                end else begin
                    enable_next = 1'b1;
                    dir_next    = (cnt_in < lo_reg) ? DIR_UP : DIR_DOWN;
                end
            end
            UP: begin
                enable_next = 1'b1;
                dir_next    = DIR_UP;
                if (cnt_ext + 1'b1 == hi_ext) begin
                    state_next = DWELL_HI;
                end
            end
            DWELL_HI: begin
                if (dwell_expire) begin
                    state_next = DOWN;
                end
            end
            DOWN: begin
                enable_next = 1'b1;
                dir_next    = DIR_DOWN;
                if (cnt_ext == lo_ext + 1'b1) begin
                    pass_cnt_next = (pass_cnt_reg == '1) ? pass_cnt_reg : pass_cnt_reg + 1'b1;
                    if (passes_reg != '0 && pass_cnt_next == passes_reg) begin
                        state_next = DONE;
                    end else begin
                        state_next = DWELL_LO;
                    end
                end
            end
            DWELL_LO: begin
                if (dwell_expire) begin
                    state_next = UP;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Abort overrides everything decided above, including an IDLE start.
        if (abort) begin
            state_next    = IDLE;
            enable_next   = 1'b0;
            dir_next      = dir_reg;
            pass_cnt_next = pass_cnt_reg;
            err_next      = err_reg;
            latch         = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            lo_reg       <= '0;
            hi_reg       <= '0;
            dwell_reg    <= '0;
            passes_reg   <= '0;
            pass_cnt_reg <= '0;
            err_reg      <= 1'b0;
            dir_reg      <= DIR_DOWN;
        end else begin
            state_reg    <= state_next;
            pass_cnt_reg <= pass_cnt_next;
            err_reg      <= err_next;
            dir_reg      <= dir_next;
            if (latch) begin
                lo_reg     <= lo_bound;
                hi_reg     <= hi_bound;
                dwell_reg  <= dwell;
                passes_reg <= passes;
            end
        end
    end

    assign cnt_enable  = enable_next;
    assign cnt_up_down = dir_next;
    assign busy        = (state_reg != IDLE);
    assign done        = (state_reg == DONE) && !abort;
    assign err         = err_reg;
    assign pass_cnt    = pass_cnt_reg;

endmodule
